ai_policy_engine: RTL
=====================

# ai_policy_engine

Parametrised, sequential successor to the pong AI policy lookup. On a `start` pulse it does five things in turn:
- snapshots the ball and paddle state;
- projects each ball `LOOKAHEAD` frames ahead;
- sorts the balls by projected x with a stable multi-cycle sort;
- encodes each ball/paddle vertical relation as a base-3 digit of a Q-table address;
- reads the external weight ROM and outputs the paddle action.

It sits between the game-state registers and the weight block RAM in the game server.

## Interface
Parameters:
- `NUM_BALLS`, 5: balls considered (≥2).
- `NUM_PADDLES`, 2: AI-controlled paddles (≥1).
- `COORD_W`, 11: signed coordinate/velocity width.
- `LOOKAHEAD`, 3: projection multiplier (frames).
- `HALF_PAD_HEIGHT`, 40: paddle half height.
- `ADDR_W`, 16: ROM address width; must satisfy 2^ADDR_W ≥ 3^(NUM_BALLS·NUM_PADDLES).
- `MEM_LAT`, 1: ROM read latency in cycles (≥1).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new decision; sampled only in IDLE.
- `ball_posx`, `ball_posy`, `ball_velx`, `ball_vely` in NUM_BALLS·COORD_W each: packed, ball i at bits [i·COORD_W +: COORD_W], signed.
- `paddle_posy` in NUM_PADDLES·COORD_W: packed signed paddle centres.
- `mem_addr` out ADDR_W: registered ROM address.
- `mem_rdata` in 2: ROM data, valid MEM_LAT cycles after `mem_addr` changes.
- `action` out 3: chosen action = {1'b0, rdata} + 1.
- `action_valid` out 1: one-cycle pulse when `action` updates.
- `busy` out 1: high while a decision is in progress.

## Operation
- FSM states are IDLE → SORT → ENCODE → FETCH → IDLE. `busy` = (state ≠ IDLE).
- **IDLE:** on the edge where `start`=1, register every ball and paddle input, plus projected positions:
  - Projected positions are computed in COORD_W-bit two's complement (wrap): fx = posx + LOOKAHEAD·velx, fy = posy + LOOKAHEAD·vely.
  - If fx < 0, fx := 0. If fy < 0, fy := −fy.
  - Initialise the index list to 0..NUM_BALLS−1. Go to SORT.
- **SORT:** odd-even transposition sort, NUM_BALLS cycles.
  - Cycle c compares adjacent pairs starting at index c mod 2.
  - Swap only if fx[left] > fx[right] (strict, signed), so the sort is stable: equal x keeps lower original index first.
- **ENCODE:** one digit per cycle, NUM_BALLS·NUM_PADDLES cycles. Digit order runs from d = D−1 down to 0, where d = k·NUM_PADDLES + p, k is the sorted rank (0 = smallest fx) and p is the paddle index.
  - Digit value: 1 if fy_k > paddle_p + HALF_PAD_HEIGHT; 2 if fy_k < paddle_p − HALF_PAD_HEIGHT; else 0. All comparisons signed.
  - Horner accumulate: acc := acc·3 + digit, in ADDR_W bits (wraps).
  - On the last digit, load `mem_addr` ← final acc and go to FETCH.
- **FETCH:** wait MEM_LAT cycles with `mem_addr` held. On the final edge:
  - `action` ← {1'b0, mem_rdata} + 1 and `action_valid` ← 1.
  - Return to IDLE.
- `action` and `mem_addr` hold their values between decisions.
- `start` while busy is ignored, not queued. `start` high in the cycle `action_valid` is high is accepted, since the FSM is already in IDLE.
- Live inputs are ignored after the capture edge.

## Timing
- Reset values: state IDLE, `action`=3'd1, `action_valid`=0, `busy`=0, `mem_addr`=0, accumulator 0.
- Latency, with `start` sampled at edge e:
  - `busy` is high from after e.
  - `mem_addr` becomes final after edge e+NUM_BALLS+NUM_BALLS·NUM_PADDLES.
  - `action`/`action_valid` update at edge e+NUM_BALLS+NUM_BALLS·NUM_PADDLES+MEM_LAT; with defaults this is e+16.
  - At that same edge `busy` falls.
- `action_valid` is exactly one cycle wide. The back-to-back decision period is latency+1 cycles.
- `rst` asserted in any state:
  - Next edge forces all reset values.
  - An in-flight decision is aborted; no `action_valid`.
  - `rst` dominates `start` in the same cycle.
- Only `mem_addr` drives the ROM; `mem_rdata` is sampled only on the final FETCH edge.

## Test plan
Defaults unless stated: paddles at y=200/200, velocities 0 unless stated, ROM contents = addr mod 4.
- **Reset:** assert `rst` 2 cycles → `action`=1, `action_valid`=0, `busy`=0, `mem_addr`=0.
- **All balls centred:** all y=200, x=10..50, `start` → `mem_addr`=0, `action`=1, `action_valid` pulse exactly at start edge+16, `busy` high 16 cycles.
- **Sort order:** x = {500,100,300,400,200}, ball1 y=300, others y=200 → sorted rank 0 is ball1, d0=d1=1 → `mem_addr`=4, `action`=1.
- **Clamp/reflect:**
  - Setup: ball0 pos (5,10), vel (−4,−10) → fx=0, fy=20; others x=100..400, y=200.
  - Response: `mem_addr`=8, `action`=1.
- **Tie + latency parameter:** MEM_LAT=2, balls 0 and 3 both x=0, ball3 y=300, ball0 y=200 → ball0 ranks first, ball3 rank 1 → `mem_addr`=36, `action`=1, valid at edge+17.
- **Abort/ignore:**
  - Pulse `start` again at edge+3 → ignored, single `action_valid`.
  - New run, `rst` at edge+8 → no `action_valid`, `busy`=0 and `action`=1 after the reset edge.
  - Next `start` completes normally.

Source files
------------

// File: rtl/ai_policy_engine.sv
// ai_policy_engine: projects and sorts balls, encodes ball/paddle relations into a Q-table address, returns the ROM action
module ai_policy_engine #(
    parameter int NUM_BALLS       = 5,
    parameter int NUM_PADDLES     = 2,
    parameter int COORD_W         = 11,
    parameter int LOOKAHEAD       = 3,
    parameter int HALF_PAD_HEIGHT = 40,
    parameter int ADDR_W          = 16,
    parameter int MEM_LAT         = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_BALLS*COORD_W-1:0]   ball_posx,
    input  logic [NUM_BALLS*COORD_W-1:0]   ball_posy,
    input  logic [NUM_BALLS*COORD_W-1:0]   ball_velx,
    input  logic [NUM_BALLS*COORD_W-1:0]   ball_vely,
    input  logic [NUM_PADDLES*COORD_W-1:0] paddle_posy,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [1:0]                     mem_rdata,
    output logic [2:0]                     action,
    output logic                           action_valid,
    output logic                           busy
);
    localparam int CW = $clog2(NUM_BALLS * NUM_PADDLES + NUM_BALLS + MEM_LAT + 1);
    localparam int KW = $clog2(NUM_BALLS);
    localparam int PW = NUM_PADDLES > 1 ? $clog2(NUM_PADDLES) : 1;
    localparam int XW = COORD_W + 2;
    typedef enum logic [1:0] {IDLE, SORT, ENCODE, FETCH} state_t;
    state_t state;
    logic signed [COORD_W-1:0] fx [NUM_BALLS];
    logic signed [COORD_W-1:0] fy [NUM_BALLS];
    logic signed [COORD_W-1:0] nfx [NUM_BALLS];
    logic signed [COORD_W-1:0] nfy [NUM_BALLS];
    logic signed [COORD_W-1:0] cfx [NUM_BALLS];
    logic signed [COORD_W-1:0] cfy [NUM_BALLS];
    logic signed [COORD_W-1:0] pad [NUM_PADDLES];
    logic [CW-1:0] cnt;
    logic [KW-1:0] k;
    logic [PW-1:0] p;
    logic [ADDR_W-1:0] acc, acc_next;
    logic [1:0] digit;
    logic signed [XW-1:0] yk, top, bot;
    assign busy = state != IDLE;
    always_comb begin
        for (int i = 0; i < NUM_BALLS; i++) begin
            cfx[i] = ball_posx[i*COORD_W +: COORD_W] + COORD_W'(LOOKAHEAD) * ball_velx[i*COORD_W +: COORD_W];
            cfy[i] = ball_posy[i*COORD_W +: COORD_W] + COORD_W'(LOOKAHEAD) * ball_vely[i*COORD_W +: COORD_W];
        end
    end
    // one odd-even transposition pass; pairs are disjoint so reading the old arrays is safe
    always_comb begin
        nfx = fx;
        nfy = fy;
        for (int i = 0; i < NUM_BALLS - 1; i++) begin
            if (i[0] == cnt[0] && fx[i] > fx[i+1]) begin
                nfx[i]   = fx[i+1];
                nfx[i+1] = fx[i];
                nfy[i]   = fy[i+1];
                nfy[i+1] = fy[i];
            end
        end
    end
    // widened compare so paddle +/- half height cannot wrap
    assign yk       = XW'(fy[k]);
    assign top      = XW'(pad[p]) + XW'(HALF_PAD_HEIGHT);
    assign bot      = XW'(pad[p]) - XW'(HALF_PAD_HEIGHT);
    assign digit    = yk > top ? 2'd1 : yk < bot ? 2'd2 : 2'd0;
    assign acc_next = acc * ADDR_W'(3) + ADDR_W'(digit);
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            action       <= 3'd1;
            action_valid <= 1'b0;
            mem_addr     <= '0;
            acc          <= '0;
            cnt          <= '0;
            k            <= '0;
            p            <= '0;
        end else begin
            action_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < NUM_BALLS; i++) begin
                        fx[i] <= cfx[i] < 0 ? '0 : cfx[i];
                        fy[i] <= cfy[i] < 0 ? -cfy[i] : cfy[i];
                    end
                    for (int j = 0; j < NUM_PADDLES; j++)
                        pad[j] <= paddle_posy[j*COORD_W +: COORD_W];
                    acc   <= '0;
                    cnt   <= '0;
                    state <= SORT;
                end
                SORT: begin
                    fx  <= nfx;
                    fy  <= nfy;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NUM_BALLS - 1)) begin
                        k     <= KW'(NUM_BALLS - 1);
                        p     <= PW'(NUM_PADDLES - 1);
                        state <= ENCODE;
                    end
                end
                ENCODE: begin
                    acc <= acc_next;
                    p   <= p == '0 ? PW'(NUM_PADDLES - 1) : p - 1'b1;
                    if (p == '0) k <= k - 1'b1;
                    if (k == '0 && p == '0) begin
                        mem_addr <= acc_next;
                        cnt      <= '0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MEM_LAT - 1)) begin
                        action       <= {1'b0, mem_rdata} + 3'd1;
                        action_valid <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
